// File: rtl/risc_mem_responder.sv
// Memory responder for the mini RISC CPU: 16x8 instruction + 16x8 data memory behind a
// valid/ready request/response handshake with WAIT_CYCLES wait states. Optional macro RISC_MEM_PRELOAD_EN.
module risc_mem_responder #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_space,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers on a rising edge where rsp_valid && rsp_ready. Outputs hold until then.

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] imem [DEPTH];
    logic [DATA_W-1:0] dmem [DEPTH];

    logic              lat_we;
    logic              lat_space;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [3:0]        cnt;

    logic              accept;
    logic              enter_resp;
    logic              acc_we;
    logic              acc_space;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    assign accept    = req_valid && req_ready;
    assign dbg_state = state;

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states the access happens on the accept edge, before the latch holds the request.
    always_comb begin
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_space = req_space;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = lat_we;
            acc_space = lat_space;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= '0;
            lat_we    <= 1'b0;
            lat_space <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dmem[ADDR_W'(i)] <= '0;
                imem[ADDR_W'(i)] <= '0;
            end
`ifdef RISC_MEM_PRELOAD_EN
            imem[ADDR_W'(0)] <= DATA_W'(8'h05);
            imem[ADDR_W'(1)] <= DATA_W'(8'h43);
            imem[ADDR_W'(2)] <= DATA_W'(8'h81);
            imem[ADDR_W'(3)] <= DATA_W'(8'hC0);
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_we    <= req_we;
                lat_space <= req_space;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt       <= CNT_LOAD;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                if (acc_we) begin
                    rsp_rdata <= acc_wdata;
                    if (acc_space) dmem[acc_addr] <= acc_wdata;
                    else           imem[acc_addr] <= acc_wdata;
                end else begin
                    rsp_rdata <= acc_space ? dmem[acc_addr] : imem[acc_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_risc_mem_responder.sv
// Bench for risc_mem_responder: three instances (WAIT_CYCLES 1, 0, 3), directed transactions,
// expected responses queued by the driver and checked by an independent monitor.
module tb_risc_mem_responder;

    logic       clk;
    logic       reset;
    logic       req_valid [3];
    logic       req_ready [3];
    logic       req_we    [3];
    logic       req_space [3];
    logic [3:0] req_addr  [3];
    logic [7:0] req_wdata [3];
    logic       rsp_valid [3];
    logic       rsp_ready [3];
    logic [7:0] rsp_rdata [3];
    logic [1:0] dbg_state [3];

    logic [7:0] exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    risc_mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(1)) u0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_space(req_space[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .dbg_state(dbg_state[0]));

    risc_mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_space(req_space[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .dbg_state(dbg_state[1]));

    risc_mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(3)) u2 (
        .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_space(req_space[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .dbg_state(dbg_state[2]));

    function automatic int wc(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset && rsp_valid[i] && rsp_ready[i]) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp u%0d: got %0h expected none", i, rsp_rdata[i]);
                end else begin
                    check($sformatf("rsp_data_u%0d", i), 32'(rsp_rdata[i]), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // driver: one full transaction; bp = cycles of response back-pressure
    task automatic txn(input int i, input logic we, input logic sp, input logic [3:0] a,
                       input logic [7:0] wd, input logic [7:0] ex, input int bp, output time acc_t);
        int n;
        int lat;
        int leak;
        req_we[i]    = we;
        req_space[i] = sp;
        req_addr[i]  = a;
        req_wdata[i] = wd;
        req_valid[i] = 1'b1;
        rsp_ready[i] = (bp == 0);
        n = 0;
        @(negedge clk);
        while (!req_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_budget", 32'(n < 50), 32'd1);
        exp_q.push_back(ex);
        @(posedge clk);
        acc_t = $time;
        #1;
        req_valid[i] = 1'b0;
        req_addr[i]  = ~a;
        req_wdata[i] = ~wd;
        req_we[i]    = ~we;
        req_space[i] = ~sp;
        lat  = 0;
        leak = 0;
        do begin
            @(negedge clk);
            lat++;
            if (req_ready[i]) leak++;
        end while (!rsp_valid[i] && lat < 50);
        check($sformatf("latency_u%0d", i), 32'(lat), 32'(wc(i) + 1));
        check("req_ready_low_while_busy", 32'(leak), 32'd0);
        if (bp > 0) begin
            for (int k = 0; k < bp; k++) begin
                if (k > 0) @(negedge clk);
                check("bp_rsp_valid", 32'(rsp_valid[i]), 32'd1);
                check("bp_rsp_rdata", 32'(rsp_rdata[i]), 32'(ex));
                check("bp_req_ready", 32'(req_ready[i]), 32'd0);
            end
            @(posedge clk);
            #1 rsp_ready[i] = 1'b1;
            @(posedge clk);
            #1;
            check("bp_release_idle", 32'(dbg_state[i]), 32'd0);
            check("bp_release_valid", 32'(rsp_valid[i]), 32'd0);
        end else begin
            @(posedge clk);
            #1;
        end
        check("ready_after_rsp", 32'(req_ready[i]), 32'd1);
        rsp_ready[i] = 1'b1;
    endtask

    initial begin : stim
        time t0;
        time t1;
        logic [7:0] prog [4];
        prog[0] = 8'h05;
        prog[1] = 8'h43;
        prog[2] = 8'h81;
        prog[3] = 8'hC0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_space[i] = 1'b0;
            req_addr[i]  = 4'h0;
            req_wdata[i] = 8'h00;
            rsp_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            check("rst_req_ready", 32'(req_ready[i]), 32'd1);
            check("rst_rsp_rdata", 32'(rsp_rdata[i]), 32'd0);
            check("rst_state", 32'(dbg_state[i]), 32'd0);
        end
        @(posedge clk);
        #1;

        // instruction memory contents after reset
`ifdef RISC_MEM_PRELOAD_EN
        for (int k = 0; k < 4; k++) txn(0, 1'b0, 1'b0, 4'(k), 8'h00, prog[k], 0, t0);
        txn(0, 1'b0, 1'b0, 4'h4, 8'h00, 8'h00, 0, t0);
`else
        txn(0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 0, t0);
        for (int k = 0; k < 4; k++) txn(0, 1'b1, 1'b0, 4'(k), prog[k], prog[k], 0, t0);
        for (int k = 0; k < 4; k++) txn(0, 1'b0, 1'b0, 4'(k), 8'h00, prog[k], 0, t0);
`endif

        // data write / read-after-write / untouched location
        txn(0, 1'b1, 1'b1, 4'h1, 8'h08, 8'h08, 0, t0);
        txn(0, 1'b0, 1'b1, 4'h1, 8'h00, 8'h08, 0, t0);
        txn(0, 1'b0, 1'b1, 4'h2, 8'h00, 8'h00, 0, t0);
        txn(0, 1'b0, 1'b0, 4'h1, 8'h00, prog[1] & {8{`ifdef RISC_MEM_PRELOAD_EN 1'b1 `else 1'b1 `endif}}, 0, t0);

        // back-pressure
        txn(0, 1'b0, 1'b1, 4'h1, 8'h00, 8'h08, 5, t0);

        // zero wait states, back-to-back instruction reads at 0xF
        txn(1, 1'b0, 1'b0, 4'hF, 8'h00, 8'h00, 0, t0);
        txn(1, 1'b1, 1'b0, 4'hF, 8'h3C, 8'h3C, 0, t0);
        txn(1, 1'b0, 1'b0, 4'hF, 8'h00, 8'h3C, 0, t0);
        txn(1, 1'b0, 1'b0, 4'hF, 8'h00, 8'h3C, 0, t1);
        check("zero_wait_accept_spacing", 32'((t1 - t0) / 10), 32'd2);

        // three wait states, then reset during WAIT drops a pending write
        txn(2, 1'b0, 1'b1, 4'h3, 8'h00, 8'h00, 0, t0);
        txn(2, 1'b0, 1'b1, 4'h3, 8'h00, 8'h00, 0, t1);
        check("wait3_accept_spacing", 32'((t1 - t0) / 10), 32'd5);
        req_we[2]    = 1'b1;
        req_space[2] = 1'b1;
        req_addr[2]  = 4'h3;
        req_wdata[2] = 8'hAA;
        req_valid[2] = 1'b1;
        @(negedge clk);
        check("rstmid_ready_before", 32'(req_ready[2]), 32'd1);
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_in_wait", 32'(dbg_state[2]), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rstmid_rsp_valid", 32'(rsp_valid[2]), 32'd0);
        check("rstmid_state_idle", 32'(dbg_state[2]), 32'd0);
        check("rstmid_req_ready", 32'(req_ready[2]), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        txn(2, 1'b0, 1'b1, 4'h3, 8'h00, 8'h00, 0, t0);
        txn(0, 1'b0, 1'b1, 4'h1, 8'h00, 8'h00, 0, t0);

        repeat (4) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
